rv_run_controller: RTL and testbench
====================================

// Module: rv_run_controller
// PURPOSE
//   Synthesizable run/reset sequencer and end-of-test monitor for the rv32i_core bench.
//   Generates the core reset and bounds the run with a cycle watchdog.
//   Detects pass/fail signature values on the write-back stream and reports a latched verdict.
//   Replaces fixed-delay reset/finish sequencing; the bench calls $finish when test_done rises.
// PARAMETERS
//   XLEN          32            width of the write-back data bus
//   CNT_W         32            width of the cycle and retire counters
//   RESET_CYCLES  2             cycles core_rst is held after entering RESET (>=1)
//   MAX_CYCLES    100           RUN-cycle budget before timeout (>=1, < 2**CNT_W)
//   PASS_SIG      32'h600D_600D write-back value that signals pass
//   FAIL_SIG      32'hBAD0_BAD0 write-back value that signals fail (!= PASS_SIG)
//   HANG_CYCLES   16            idle write-back cycles that signal a hang (only with RUN_HANG_DETECT_EN)
// PORTS
//   clk            in   1      single clock; all state updates on the rising edge
//   rst            in   1      asynchronous, active-high reset
//   wb_valid       in   1      write-back data is valid this cycle
//   wb_write_data  in   XLEN   write-back data from the core
//   core_rst       out  1      reset to the core, active-high, registered
//   test_done      out  1      verdict latched (sticky until rst)
//   test_pass      out  1      pass signature seen
//   test_fail      out  1      fail signature seen
//   test_timeout   out  1      MAX_CYCLES reached without a signature
//   test_hang      out  1      hang detected (tied 0 without RUN_HANG_DETECT_EN)
//   cycle_count    out  CNT_W  RUN cycles elapsed, frozen in DONE
//   retire_count   out  CNT_W  wb_valid beats counted in RUN, frozen in DONE
// BEHAVIOUR
//   Reset: state=RESET, core_rst=1, all flags=0, counters=0, reset-cycle counter=0.
//   FSM RESET -> RUN -> DONE; DONE is terminal until rst.
//   RESET: hold core_rst=1 for exactly RESET_CYCLES clk edges after rst falls,
//     then go to RUN with core_rst=0 (registered; no combinational path from rst).
//   RUN: cycle_count += 1 every cycle; retire_count += 1 per wb_valid.
//     wb_valid is ignored while core_rst=1.
//   Verdict evaluation in RUN, priority high->low:
//     wb_valid & data==FAIL_SIG -> test_fail.
//     wb_valid & data==PASS_SIG -> test_pass.
//     cycle_count==MAX_CYCLES-1 -> test_timeout.
//     Hang (optional feature) -> test_hang.
//   Exactly one verdict flag is set; test_done is set on the same edge; go to DONE.
//     Latency: flag is visible 1 cycle after the qualifying input.
//   Same cycle as timeout boundary: a signature wins (e.g. pass with cycle_count=MAX_CYCLES-1).
//   Counters must not wrap; MAX_CYCLES < 2**CNT_W guarantees this. retire_count saturates at all-ones.
//   DONE: outputs and counters frozen; core_rst stays 0; further wb_valid is ignored.
//   rst asserted in any state (including mid-RUN): immediate async return to reset values.
//     core_rst=1 asynchronously.
// CONFIGURATION
//   RUN_HANG_DETECT_EN defined: an idle counter clears on each wb_valid and increments otherwise in RUN.
//     Reaching HANG_CYCLES sets test_hang and test_done.
//   RUN_HANG_DETECT_EN undefined: no idle counter; test_hang is constant 0.
// STRUCTURE
//   Package rv_run_pkg:
//     run_state_t enum {RUN_RESET, RUN_ACTIVE, RUN_DONE}.
//     Verdict enum {V_NONE, V_PASS, V_FAIL, V_TIMEOUT, V_HANG}.
//     Default PASS_SIG and FAIL_SIG constants.
//   One sub-module: rv_run_sat_cnt, a parametrised saturating counter with clr and inc.
//     Used for the reset, cycle, retire and idle counts.
//   The verdict is held as one run_verdict register; flags are decoded from it, guaranteeing one-hot.
// TESTING
//   rst 1->0, then nothing: core_rst=1 for exactly 2 clk edges, then 0; cycle_count starts at 0.
//   RUN, wb_valid with data=32'h600D_600D at cycle 10: next cycle test_pass=1, test_done=1.
//     cycle_count frozen at 11.
//   RUN, FAIL_SIG and PASS_SIG on consecutive cycles: test_fail=1 only, test_pass stays 0.
//   No signature, wb_valid every cycle with data 0: test_timeout=1 when cycle_count=100.
//     retire_count=100.
//   PASS_SIG arriving exactly at cycle_count=99 (timeout boundary): test_pass=1, test_timeout=0.
//   rst pulsed mid-RUN at cycle 50: all flags=0, counters=0, core_rst=1 within the same cycle.
//     With RUN_HANG_DETECT_EN: 16 idle cycles -> test_hang=1.

Source files
------------

// File: rtl/rv_run_pkg.sv
// -----------------------------------------------------------------------------
// rv_run_pkg
//   Shared types and default constants for the rv32i_core run controller.
//   - run_state_t : sequencer phase (reset hold, active run, terminal done)
//   - verdict_t   : latched end-of-test verdict; flags are decoded from it
//   - DEF_PASS_SIG / DEF_FAIL_SIG : default write-back signature values
// -----------------------------------------------------------------------------
package rv_run_pkg;

    typedef enum logic [1:0] {
        RUN_RESET,
        RUN_ACTIVE,
        RUN_DONE
    } run_state_t;

    typedef enum logic [2:0] {
        V_NONE,
        V_PASS,
        V_FAIL,
        V_TIMEOUT,
        V_HANG
    } verdict_t;

    localparam logic [31:0] DEF_PASS_SIG = 32'h600D_600D;
    localparam logic [31:0] DEF_FAIL_SIG = 32'hBAD0_BAD0;

endpackage

// File: rtl/rv_run_sat_cnt.sv
// -----------------------------------------------------------------------------
// rv_run_sat_cnt
//   Parametrised up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk      in  1  rising-edge clock
//     rst      in  1  asynchronous active-high reset (count -> 0)
//     i_clr    in  1  synchronous clear, wins over i_inc
//     i_inc    in  1  increment by one unless already saturated
//     o_count  out W  current count
// -----------------------------------------------------------------------------
module rv_run_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/rv_run_controller.sv
// -----------------------------------------------------------------------------
// rv_run_controller
//   Run/reset sequencer and end-of-test monitor for the rv32i_core bench.
//   Holds the core in reset for RESET_CYCLES edges, then runs it while
//   counting cycles and retired write-backs, and latches exactly one verdict:
//   fail signature > pass signature > cycle budget timeout > hang.
//   Optional feature macro: RUN_HANG_DETECT_EN (idle write-back hang detect).
//   Ports:
//     clk            in   1      rising-edge clock
//     rst            in   1      asynchronous active-high reset
//     wb_valid       in   1      write-back data valid
//     wb_write_data  in   XLEN   write-back data
//     core_rst       out  1      registered core reset, active-high
//     test_done      out  1      any verdict latched (sticky until rst)
//     test_pass      out  1      pass signature seen
//     test_fail      out  1      fail signature seen
//     test_timeout   out  1      cycle budget exhausted
//     test_hang      out  1      idle hang detected (0 without the macro)
//     cycle_count    out  CNT_W  RUN cycles elapsed, frozen once done
//     retire_count   out  CNT_W  wb_valid beats in RUN, frozen once done
// -----------------------------------------------------------------------------
module rv_run_controller
    import rv_run_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter int               CNT_W        = 32,
    parameter int               RESET_CYCLES = 2,
    parameter int               MAX_CYCLES   = 100,
    parameter logic [XLEN-1:0]  PASS_SIG     = XLEN'(DEF_PASS_SIG),
    parameter logic [XLEN-1:0]  FAIL_SIG     = XLEN'(DEF_FAIL_SIG),
    parameter int               HANG_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [XLEN-1:0]  wb_write_data,
    output logic             core_rst,
    output logic             test_done,
    output logic             test_pass,
    output logic             test_fail,
    output logic             test_timeout,
    output logic             test_hang,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    run_state_t       r_state, w_state_nxt;
    verdict_t         r_verdict, w_verdict_nxt;
    logic             r_core_rst, w_core_rst_nxt;
    logic [RST_W-1:0] w_rst_cnt;
    logic             w_in_reset;
    logic             w_in_run;
    logic             w_beat;
    logic             w_hang;

    assign w_in_reset = (r_state == RUN_RESET);
    assign w_in_run   = (r_state == RUN_ACTIVE);
    // A beat only counts while running with the core out of reset; DONE and
    // RESET ignore the write-back stream entirely.
    assign w_beat     = w_in_run & ~r_core_rst & wb_valid;

    rv_run_sat_cnt #(.W(RST_W)) u_rst_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_inc   (w_in_reset),
        .o_count (w_rst_cnt)
    );

    rv_run_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_inc   (w_in_run),
        .o_count (cycle_count)
    );

    rv_run_sat_cnt #(.W(CNT_W)) u_retire_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_inc   (w_beat),
        .o_count (retire_count)
    );

`ifdef RUN_HANG_DETECT_EN
    localparam int IDLE_W = $clog2(HANG_CYCLES + 1);

    logic [IDLE_W-1:0] w_idle_cnt;

    rv_run_sat_cnt #(.W(IDLE_W)) u_idle_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_beat),
        .i_inc   (w_in_run & ~w_beat),
        .o_count (w_idle_cnt)
    );

    // This idle edge would be the HANG_CYCLES-th in a row.
    assign w_hang    = w_in_run & ~w_beat & (w_idle_cnt == IDLE_W'(HANG_CYCLES - 1));
    assign test_hang = (r_verdict == V_HANG);
`else
    logic w_unused_hang_cfg;

    assign w_unused_hang_cfg = (HANG_CYCLES > 0);
    assign w_hang            = 1'b0;
    assign test_hang         = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN_RESET;
            r_verdict  <= V_NONE;
            r_core_rst <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_verdict  <= w_verdict_nxt;
            r_core_rst <= w_core_rst_nxt;
        end
    end

    // NOTE: every output of this block is given its hold value first, so no
    // path through the case leaves a signal unassigned (no latch).
    always_comb begin
        w_state_nxt    = r_state;
        w_verdict_nxt  = r_verdict;
        w_core_rst_nxt = r_core_rst;

        case (r_state)
            RUN_RESET: begin
                if (w_rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
                    w_state_nxt    = RUN_ACTIVE;
                    w_core_rst_nxt = 1'b0;
                end
            end
            RUN_ACTIVE: begin
                // Signatures outrank the timeout on the boundary cycle.
                if (w_beat && (wb_write_data == FAIL_SIG)) begin
                    w_verdict_nxt = V_FAIL;
                end else if (w_beat && (wb_write_data == PASS_SIG)) begin
                    w_verdict_nxt = V_PASS;
                end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
                    w_verdict_nxt = V_TIMEOUT;
                end else if (w_hang) begin
                    w_verdict_nxt = V_HANG;
                end
                if (w_verdict_nxt != V_NONE) begin
                    w_state_nxt = RUN_DONE;
                end
            end
            default: begin
                // RUN_DONE is terminal until rst.
            end
        endcase
    end

    assign core_rst     = r_core_rst;
    assign test_done    = (r_verdict != V_NONE);
    assign test_pass    = (r_verdict == V_PASS);
    assign test_fail    = (r_verdict == V_FAIL);
    assign test_timeout = (r_verdict == V_TIMEOUT);

endmodule

// File: tb/tb_rv_run_controller.sv
// -----------------------------------------------------------------------------
// tb_rv_run_controller
//   Directed bench for rv_run_controller. A behavioural model tracks edges
//   since reset release, run cycles, retired beats and the verdict as plain
//   integers; a negedge process compares every output against it. Directed
//   sequences add hand-computed literal expectations.
//   Optional feature macro: RUN_HANG_DETECT_EN (adds the hang scenario).
// -----------------------------------------------------------------------------
module tb_rv_run_controller;

    localparam int          XLEN         = 32;
    localparam int          CNT_W        = 32;
    localparam int          RESET_CYCLES = 2;
    localparam int          MAX_CYCLES   = 100;
    localparam int          HANG_CYCLES  = 16;
    localparam logic [31:0] PASS_SIG     = 32'h600D_600D;
    localparam logic [31:0] FAIL_SIG     = 32'hBAD0_BAD0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wb_valid = 1'b0;
    logic [XLEN-1:0]  wb_write_data = '0;
    logic             core_rst;
    logic             test_done;
    logic             test_pass;
    logic             test_fail;
    logic             test_timeout;
    logic             test_hang;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;

    always #5 clk = ~clk;

    rv_run_controller #(
        .XLEN         (XLEN),
        .CNT_W        (CNT_W),
        .RESET_CYCLES (RESET_CYCLES),
        .MAX_CYCLES   (MAX_CYCLES),
        .PASS_SIG     (PASS_SIG),
        .FAIL_SIG     (FAIL_SIG),
        .HANG_CYCLES  (HANG_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid      (wb_valid),
        .wb_write_data (wb_write_data),
        .core_rst      (core_rst),
        .test_done     (test_done),
        .test_pass     (test_pass),
        .test_fail     (test_fail),
        .test_timeout  (test_timeout),
        .test_hang     (test_hang),
        .cycle_count   (cycle_count),
        .retire_count  (retire_count)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_edges;     // edges seen since rst fell, capped at RESET_CYCLES
    int unsigned m_cycles;    // run edges consumed
    int unsigned m_retire;    // valid beats during the run
    int unsigned m_idle;      // consecutive idle run edges
    bit          m_pass, m_fail, m_timeout, m_hang;

    function automatic bit m_done();
        return m_pass | m_fail | m_timeout | m_hang;
    endfunction

    always @(posedge clk or posedge rst) begin
        int unsigned k;
        if (rst) begin
            m_edges   = 0;
            m_cycles  = 0;
            m_retire  = 0;
            m_idle    = 0;
            m_pass    = 1'b0;
            m_fail    = 1'b0;
            m_timeout = 1'b0;
            m_hang    = 1'b0;
        end else if (m_edges < RESET_CYCLES) begin
            m_edges = m_edges + 1;
        end else if (!m_done()) begin
            k        = m_cycles;
            m_cycles = m_cycles + 1;
            if (wb_valid) begin
                if (m_retire != 32'hFFFF_FFFF) m_retire = m_retire + 1;
                m_idle = 0;
            end else begin
                m_idle = m_idle + 1;
            end
            if (wb_valid && wb_write_data == FAIL_SIG)      m_fail    = 1'b1;
            else if (wb_valid && wb_write_data == PASS_SIG) m_pass    = 1'b1;
            else if (k == MAX_CYCLES - 1)                   m_timeout = 1'b1;
`ifdef RUN_HANG_DETECT_EN
            else if (m_idle == HANG_CYCLES)                 m_hang    = 1'b1;
`endif
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_core_rst",     core_rst,     rst || (m_edges < RESET_CYCLES));
            check("cmp_test_done",    test_done,    m_done());
            check("cmp_test_pass",    test_pass,    m_pass);
            check("cmp_test_fail",    test_fail,    m_fail);
            check("cmp_test_timeout", test_timeout, m_timeout);
            check("cmp_test_hang",    test_hang,    m_hang);
            check("cmp_cycle_count",  cycle_count,  m_cycles);
            check("cmp_retire_count", retire_count, m_retire);
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change 1 time unit after the falling edge, well away from both
    // the sampling edge of the DUT and the compare edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Assert rst, release it and pin the reset-hold window; returns with the
    // controller in RUN at cycle_count 0.
    task automatic start_run();
        wb_valid      = 1'b0;
        wb_write_data = '0;
        rst           = 1'b1;
        step();
        check("rst_core_rst", core_rst, 1'b1);
        check("rst_cycle",    cycle_count, 0);
        check("rst_done",     test_done, 1'b0);
        rst = 1'b0;
        step();
        check("rst_hold_edge1", core_rst, 1'b1);
        step();
        check("rst_release_edge2", core_rst, 1'b0);
        check("run_cycle_start",   cycle_count, 0);
    endtask

    initial begin
        step();
        step();
        chk_en = 1'b1;

        // Pass signature at cycle 10, then the DONE freeze.
        start_run();
        repeat (10) step();
        check("idle_cycle10", cycle_count, 10);
        wb_valid      = 1'b1;
        wb_write_data = PASS_SIG;
        step();
        wb_valid = 1'b0;
        check("pass10_pass",    test_pass, 1'b1);
        check("pass10_done",    test_done, 1'b1);
        check("pass10_cycle",   cycle_count, 11);
        check("pass10_retire",  retire_count, 1);
        wb_valid      = 1'b1;
        wb_write_data = FAIL_SIG;
        repeat (3) step();
        wb_valid = 1'b0;
        check("done_frozen_fail",   test_fail, 1'b0);
        check("done_frozen_cycle",  cycle_count, 11);
        check("done_frozen_retire", retire_count, 1);
        check("done_core_rst",      core_rst, 1'b0);

        // FAIL then PASS on consecutive cycles: fail wins, pass ignored.
        start_run();
        repeat (3) step();
        wb_valid      = 1'b1;
        wb_write_data = FAIL_SIG;
        step();
        wb_write_data = PASS_SIG;
        step();
        wb_valid = 1'b0;
        check("failpass_fail",   test_fail, 1'b1);
        check("failpass_pass",   test_pass, 1'b0);
        check("failpass_cycle",  cycle_count, 4);
        check("failpass_retire", retire_count, 1);

        // Timeout with data 0 every cycle.
        start_run();
        wb_valid      = 1'b1;
        wb_write_data = '0;
        repeat (99) step();
        check("timeout_pre_done",  test_done, 1'b0);
        check("timeout_pre_cycle", cycle_count, 99);
        step();
        wb_valid = 1'b0;
        check("timeout_flag",   test_timeout, 1'b1);
        check("timeout_cycle",  cycle_count, 100);
        check("timeout_retire", retire_count, 100);

        // Pass on the timeout boundary cycle.
        start_run();
        wb_valid      = 1'b1;
        wb_write_data = '0;
        repeat (99) step();
        wb_write_data = PASS_SIG;
        step();
        wb_valid = 1'b0;
        check("boundary_pass",    test_pass, 1'b1);
        check("boundary_timeout", test_timeout, 1'b0);
        check("boundary_cycle",   cycle_count, 100);

        // rst pulsed mid-RUN: immediate return to reset values.
        start_run();
        wb_valid      = 1'b1;
        wb_write_data = 32'h0000_1234;
        repeat (50) step();
        check("midrun_cycle",  cycle_count, 50);
        check("midrun_retire", retire_count, 50);
        rst = 1'b1;
        #1;
        check("midrst_core_rst", core_rst, 1'b1);
        check("midrst_done",     test_done, 1'b0);
        check("midrst_cycle",    cycle_count, 0);
        check("midrst_retire",   retire_count, 0);

        // Pass on the very first run cycle after recovery.
        start_run();
        wb_valid      = 1'b1;
        wb_write_data = PASS_SIG;
        step();
        wb_valid = 1'b0;
        check("first_pass",  test_pass, 1'b1);
        check("first_cycle", cycle_count, 1);

`ifdef RUN_HANG_DETECT_EN
        // Idle stream: hang after HANG_CYCLES idle edges.
        start_run();
        repeat (HANG_CYCLES - 1) step();
        check("hang_pre", test_hang, 1'b0);
        step();
        check("hang_flag",  test_hang, 1'b1);
        check("hang_done",  test_done, 1'b1);
        check("hang_cycle", cycle_count, HANG_CYCLES);
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=time limit reached required=normal completion");
        $fatal(1, "watchdog expired");
    end

endmodule
